countdown_sequencer: RTL
========================

// Module: countdown_sequencer
// PURPOSE
//   Controls a WIDTH-bit decrementer as a loadable countdown. Accepts a start value over a
//   valid/ready handshake and steps it down once per PRESCALE cycles. Raises done at zero.
//   Never wraps past zero: a decrement request at zero sets a sticky underflow flag instead.
//   Sits between a host/config interface and any block that needs timed countdowns.
// PARAMETERS
//   WIDTH     4   count/load width in bits
//   PRESCALE  1   clock cycles per decrement step (>=1)
// PORTS
//   clk          in   1      single clock; all state changes on rising edge
//   rst_n        in   1      reset, asynchronous, active-low
//   load_valid   in   1      load_value offered
//   load_ready   out  1      sequencer can accept a load (IDLE or DONE only)
//   load_value   in   WIDTH  start value
//   auto_reload  in   1      1: on reaching terminal count, reload and keep running
//   start        in   1      begin (IDLE) / resume (PAUSE) countdown
//   pause        in   1      freeze countdown (RUN only)
//   abort        in   1      cancel; return to IDLE
//   count        out  WIDTH  current count
//   busy         out  1      state is RUN or PAUSE
//   done         out  1      one-cycle pulse on terminal count
//   underflow    out  1      sticky; set on decrement attempt at zero, cleared by accepted load
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset (immediate, any state):
//   - state=IDLE, count=0, reload reg=0, prescaler=0.
//   - busy=0, done=0, underflow=0, load_ready=1.
// - States IDLE, RUN, PAUSE, DONE.
// - Per-cycle priority: abort > load > pause > start > decrement tick.
// - abort (any state): ->IDLE next cycle; count=0; prescaler=0; no done; underflow unchanged.
// - Load:
//   - Accepted when load_valid && load_ready.
//   - Action: count<=load_value, reload<=load_value, underflow<=0, ->IDLE.
//   - During RUN/PAUSE, load_ready=0 and load_valid is ignored.
// - start in IDLE/DONE:
//   - count!=0: ->RUN, prescaler=0.
//   - count==0: underflow<=1, count stays 0 (never 2^WIDTH-1), no done pulse, state unchanged.
// - RUN:
//   - Prescaler counts 0..PRESCALE-1; a tick fires when it equals PRESCALE-1, then it wraps to 0.
//   - First decrement occurs PRESCALE cycles after entering RUN.
//   - Tick with count>1: count<=count-1.
//   - Tick with count==1, auto_reload=0: count<=0, done pulse, ->DONE.
//   - Tick with count==1, auto_reload=1: count<=reload, done pulse, stay RUN (count never shows 0).
// - pause in RUN:
//   - ->PAUSE; count and prescaler hold.
//   - pause coinciding with a tick: pause wins and the tick is dropped.
// - start in PAUSE: ->RUN; prescaler resumes from its held value.
// - DONE: count=0, busy=0; waits for load or start (start => underflow per the rule above).
// - done is registered and high exactly one cycle per terminal count. count is registered.
// - Arithmetic is WIDTH-bit unsigned. Subtraction is only performed when count>=1.
// TESTING (WIDTH=4, PRESCALE=1 unless stated)
// - Load 5, start -> count 5,4,3,2,1,0 on consecutive cycles.
//   done=1 only in the cycle count becomes 0; then DONE, busy=0, underflow=0.
// - Load 1, start -> count 0, done pulse.
//   Then start again -> underflow=1, count stays 0 (not 15).
//   Then load 8 -> underflow=0, count=8.
// - Load 0, start -> underflow=1, count=0, no done, state IDLE.
// - PRESCALE=2, auto_reload=1, load 3, start -> count 3,3,2,2,1,1,3,3,...
//   done pulses on each reload; busy stays 1.
// - Load 9, start:
//   - Pause at count 6 for 5 cycles -> count holds 6.
//   - load_valid with 2 during RUN -> load_ready=0, count unaffected.
//   - start resumes; abort -> IDLE, count=0, no done.
// - Load 12, start; drop rst_n asynchronously at count 10 -> outputs reset values immediately.
//   load_ready=1 while in reset.

Source files
------------

// File: rtl/countdown_sequencer_if.sv
// -----------------------------------------------------------------------------
// countdown_sequencer_if
//   Load handshake between a host/config block and countdown_sequencer.
//   The host offers a start value with load_valid/load_value and the sequencer
//   answers with load_ready. A load is accepted in any cycle where
//   load_valid && load_ready.
//
//   Signals
//     load_valid  host -> seq   load_value is offered
//     load_value  host -> seq   start value, WIDTH bits
//     load_ready  seq  -> host  sequencer can accept a load
//
//   Modports
//     master : host side (drives valid/value, observes ready)
//     slave  : sequencer side (observes valid/value, drives ready)
// -----------------------------------------------------------------------------
interface countdown_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
//   Loadable countdown controller. A start value arrives over the load
//   handshake; after start the count steps down once every PRESCALE cycles.
//   Reaching zero raises a one-cycle done pulse and either parks in DONE or,
//   with auto_reload, reloads the last loaded value and keeps running.
//   The count never wraps below zero: a start at zero sets the sticky
//   underflow flag instead, which only an accepted load clears.
//
//   Parameters
//     WIDTH     count / load width in bits
//     PRESCALE  clock cycles per decrement step (>= 1)
//
//   Ports
//     clk          in   single clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     load_if      slave modport of countdown_sequencer_if (load handshake)
//     auto_reload  in   reload and keep running on terminal count
//     start        in   begin (IDLE/DONE) or resume (PAUSE)
//     pause        in   freeze the countdown (RUN only)
//     abort        in   cancel, return to IDLE with count 0
//     count        out  current count (registered)
//     busy         out  high in RUN or PAUSE
//     done         out  one-cycle pulse per terminal count (registered)
//     underflow    out  sticky decrement-at-zero flag
//
//   Per-cycle priority: abort > load > pause > start > decrement tick.
// -----------------------------------------------------------------------------
module countdown_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    countdown_sequencer_if.slave  load_if,
    input  logic                  auto_reload,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  underflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // A one-bit prescaler is kept even for PRESCALE == 1; it simply stays 0.
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  count_q,  count_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic [PS_W-1:0]   pre_q,    pre_d;
    logic              done_q,   done_d;
    logic              uf_q,     uf_d;

    logic              load_ready;
    logic              load_fire;
    logic              tick;

    // Loads are only taken while the countdown is not in progress.
    assign load_ready         = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_if.load_ready = load_ready;
    assign load_fire          = load_if.load_valid && load_ready;
    assign tick               = (pre_q == PS_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        done_d   = 1'b0;
        uf_d     = uf_q;

        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else if (load_fire) begin
            state_d  = S_IDLE;
            count_d  = load_if.load_value;
            reload_d = load_if.load_value;
            pre_d    = '0;
            uf_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (pause) begin
                        // Pause wins over a coincident tick; prescaler holds.
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_DONE;
                            end
                        end else begin
                            // Defensive: a tick at zero never subtracts.
                            uf_d    = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        pre_d = pre_q + PS_W'(1);
                    end
                end
                S_PAUSE: begin
                    // A held pause outranks start, so resume needs pause low.
                    if (!pause && start) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    // IDLE and DONE: start either runs or flags underflow.
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = S_RUN;
                            pre_d   = '0;
                        end else begin
                            uf_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            done_q   <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            uf_q     <= uf_d;
        end
    end

    assign count     = count_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done      = done_q;
    assign underflow = uf_q;

endmodule
